// File: rtl/branch_redirect_ctrl_if.sv
// Bundles the EX-stage branch inputs and the redirect/flush outputs of branch_redirect_ctrl.
// master = EX stage / pipeline control side, slave = the redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              ex_branch;
  logic [3:0]        ex_funct;
  logic              ex_zero;
  logic              ex_is_greater;
  logic [ADDR_W-1:0] ex_target;
  logic              stall;
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              redirect_busy;
  logic [CNT_W-1:0]  stat_resolved;
  logic [CNT_W-1:0]  stat_taken;

  modport master (
    output ex_branch, ex_funct, ex_zero, ex_is_greater, ex_target, stall,
    input  pc_sel, pc_target, flush_if_id, flush_id_ex, redirect_busy,
    input  stat_resolved, stat_taken
  );

  modport slave (
    input  ex_branch, ex_funct, ex_zero, ex_is_greater, ex_target, stall,
    output pc_sel, pc_target, flush_if_id, flush_id_ex, redirect_busy,
    output stat_resolved, stat_taken
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Stall-aware branch redirect sequencer: resolves EX-stage branches and squashes one advancing cycle.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input logic                  clk,
  input logic                  reset,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t            state;
  logic              redirect_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic              taken;
  logic              resolve;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    taken = 1'b0;
    case (bus.ex_funct[2:0])
      3'b000:  taken = bus.ex_zero;
      3'b001:  taken = !bus.ex_zero;
      3'b101:  taken = bus.ex_is_greater;
      default: taken = 1'b0;
    endcase
  end

  // funct7[5] has no meaning for conditional branches.
  logic unused_funct7;
  assign unused_funct7 = bus.ex_funct[3];

  assign resolve = (state == IDLE) && bus.ex_branch && !bus.stall;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      redirect_q  <= 1'b0;
      pc_target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (resolve && taken) begin
            state       <= REDIRECT;
            redirect_q  <= 1'b1;
            pc_target_q <= bus.ex_target;
          end
        end
        REDIRECT: begin
          // EX holds a wrong-path instruction here, so ex_* are ignored.
          if (!bus.stall) begin
            state      <= IDLE;
            redirect_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_sel        = redirect_q;
  assign bus.flush_if_id   = redirect_q;
  assign bus.flush_id_ex   = redirect_q;
  assign bus.redirect_busy = redirect_q;
  assign bus.pc_target     = pc_target_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] resolved_q;
  logic [CNT_W-1:0] taken_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resolved_q <= '0;
      taken_q    <= '0;
    end else if (resolve) begin
      resolved_q <= resolved_q + 1'b1;
      if (taken) taken_q <= taken_q + 1'b1;
    end
  end

  assign bus.stat_resolved = resolved_q;
  assign bus.stat_taken    = taken_q;
`else
  assign bus.stat_resolved = {CNT_W{1'b0}};
  assign bus.stat_taken    = {CNT_W{1'b0}};
`endif

endmodule
